// File: rtl/reg_pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a WIDTH-bit payload register.
//   clk      rising-edge clock
//   rst      synchronous active-high reset, clears valid and payload
//   ld_i     stage takes a new value from its source this cycle
//   src_v_i  source valid; becomes the new valid bit when ld_i = 1
//   src_d_i  source payload; captured only when ld_i and src_v_i are both 1
//   v_o      stage valid
//   d_o      stage payload
module reg_pipe_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_i,
   input  logic             src_v_i,
   input  logic [WIDTH-1:0] src_d_i,
   output logic             v_o,
   output logic [WIDTH-1:0] d_o
);

   logic             v_q;
   logic [WIDTH-1:0] d_q;

   // Payload only moves with a valid source, so garbage on an idle input
   // never reaches the register.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= 1'b0;
         d_q <= '0;
      end else if (ld_i) begin
         v_q <= src_v_i;
         if (src_v_i) begin
            d_q <= src_d_i;
         end
      end
   end

   assign v_o = v_q;
   assign d_o = d_q;

endmodule

// File: rtl/reg_pipe.sv
// Elastic register pipeline: delays a WIDTH-bit payload by DEPTH registered
// stages with a valid/ready handshake, stage-by-stage backpressure and
// bubble collapse.
//   clk        rising-edge clock
//   rst        synchronous active-high reset (overrides flush and handshakes)
//   flush      discard all in-flight words at the next edge
//   in_valid   upstream payload valid
//   in_ready   pipeline accepts in_data this cycle
//   in_data    upstream payload
//   out_valid  last stage holds a valid payload
//   out_ready  downstream accepts out_data this cycle
//   out_data   last-stage payload
//   count      number of valid stages, 0..DEPTH
module reg_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] count
);

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] rdy;
   logic [WIDTH-1:0] d [DEPTH];
   logic             accept;
   logic             emit;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Ready ripples back from out_ready: a stage can load if it is empty or
   // the stage after it can load. Built in one process from the output end
   // so the chain is a plain combinational cascade.
   always_comb begin
      rdy = '0;
      rdy[DEPTH-1] = !v[DEPTH-1] | out_ready;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         rdy[i] = !v[i] | rdy[i+1];
      end
   end

   assign in_ready = rdy[0] & !flush;
   assign accept   = in_valid & in_ready;
   assign emit     = out_valid & out_ready;

   // Flush forces every stage to load an invalid source, which clears the
   // valid bits while leaving the payload registers untouched.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             src_v;
      logic [WIDTH-1:0] src_d;

      if (i == 0) begin : g_head
         assign src_v = accept;
         assign src_d = in_data;
      end else begin : g_body
         assign src_v = v[i-1] & !flush;
         assign src_d = d[i-1];
      end

      reg_pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .ld_i    (rdy[i] | flush),
         .src_v_i (src_v),
         .src_d_i (src_d),
         .v_o     (v[i]),
         .d_o     (d[i])
      );
   end

   always_comb begin
      count_d = count_q + CNT_W'(accept) - CNT_W'(emit);
      if (flush) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];
   assign count     = count_q;

endmodule

// File: tb/tb_reg_pipe.sv
// Bench for reg_pipe: directed phases followed by randomized traffic. The
// reference model keeps the in-flight words as a queue with their accept
// cycle; the oldest word is visible at the output once it has aged
// DEPTH-1 edges. A separate monitor pops a scoreboard on every emit.
module tb_reg_pipe;
   parameter int WIDTH = 8;
   parameter int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] count;

   int n_cmp = 0;
   int n_err = 0;

   logic [WIDTH-1:0] sb_q[$];
   int               m_stamp[$];
   int               cyc = 0;

   reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock cycle of stimulus plus model-based checks of the outputs
   // that must hold for the current model state.
   task automatic step(input logic iv, input logic [WIDTH-1:0] id,
                       input logic ordy, input logic fl, input logic r);
      logic m_ov;
      logic m_ir;
      logic acc;
      logic emt;
      @(negedge clk);
      rst       = r;
      flush     = fl;
      in_valid  = iv;
      in_data   = iv ? id : WIDTH'($urandom);
      out_ready = ordy;
      #1;
      m_ov = (m_stamp.size() > 0) && (cyc >= m_stamp[0] + DEPTH - 1);
      m_ir = ((m_stamp.size() < DEPTH) || ordy) && !fl;
      if (!r) begin
         chk("in_ready", in_ready, m_ir);
         chk("out_valid", out_valid, m_ov);
         chk("count", count, m_stamp.size());
      end
      @(posedge clk);
      cyc++;
      acc = iv && m_ir;
      emt = m_ov && ordy;
      if (r || fl) begin
         m_stamp.delete();
         sb_q.delete();
      end else begin
         if (emt) void'(m_stamp.pop_front());
         if (acc) begin
            m_stamp.push_back(cyc);
            sb_q.push_back(id);
         end
      end
   endtask

   // Monitor: pops the scoreboard on every real emit and checks that a
   // stalled output word does not change.
   logic             prev_hold = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (!rst) begin
            if (prev_hold && out_valid) chk("out_data_stable", out_data, prev_data);
            if (out_valid && out_ready) begin
               if (sb_q.size() == 0) begin
                  chk("emit_expected", 1, 0);
               end else begin
                  chk("out_data", out_data, sb_q.pop_front());
               end
            end
         end
         prev_hold = !rst && !flush && out_valid && !out_ready;
         prev_data = out_data;
      end
   end

   initial begin
      // 1: reset
      step(0, '0, 1, 0, 1);
      step(0, '0, 1, 0, 1);
      step(0, '0, 1, 0, 0);
      chk("reset_out_data", out_data, 0);

      // 2: unstalled stream
      for (int k = 0; k < 8; k++) step(1, WIDTH'(32'h01 + k), 1, 0, 0);
      for (int k = 0; k < DEPTH + 2; k++) step(0, '0, 1, 0, 0);

      // 3: stalled push, then release
      for (int k = 0; k < 6; k++) step(1, WIDTH'(32'hA0 + k), 0, 0, 0);
      chk("stall_count", count, DEPTH);
      chk("stall_out_data", out_data, WIDTH'(32'hA0));
      for (int k = 0; k < DEPTH + 2; k++) step(0, '0, 1, 0, 0);

      // 4: full pipeline, accept and emit together
      for (int k = 0; k < DEPTH; k++) step(1, WIDTH'(32'h40 + k), 0, 0, 0);
      for (int k = 0; k < 10; k++) step(1, WIDTH'(32'h50 + k), 1, 0, 0);
      chk("full_flow_count", count, DEPTH);
      for (int k = 0; k < DEPTH + 2; k++) step(0, '0, 1, 0, 0);

      // 5: bubbles with output stalled
      for (int k = 0; k < 2 * DEPTH + 2; k++) step(k % 2 == 0, WIDTH'(32'h60 + k), 0, 0, 0);
      chk("bubble_count", count, DEPTH);
      for (int k = 0; k < DEPTH + 2; k++) step(0, '0, 1, 0, 0);

      // 6: flush with partial occupancy
      for (int k = 0; k < DEPTH - 1; k++) step(1, WIDTH'(32'h70 + k), 0, 0, 0);
      step(1, WIDTH'(32'h7F), 0, 1, 0);
      step(0, '0, 0, 0, 0);
      chk("flush_count", count, 0);

      // 7: reset while full
      for (int k = 0; k < DEPTH; k++) step(1, WIDTH'(32'h80 + k), 0, 0, 0);
      step(1, WIDTH'(32'h8F), 1, 0, 1);
      step(0, '0, 0, 0, 0);
      chk("midrst_out_data", out_data, 0);

      // 8: randomized traffic
      for (int k = 0; k < 1500; k++) begin
         step($urandom_range(0, 3) != 0, WIDTH'($urandom),
              $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0,
              $urandom_range(0, 300) == 0);
      end
      for (int k = 0; k < DEPTH + 2; k++) step(0, '0, 1, 0, 0);
      #5;
      chk("drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
